// File: rtl/alu_scheduler_if.sv
// Bundle between two requesters, the scheduler and the shared ALU.
// The slave modport is the scheduler; master is the surrounding environment.
interface alu_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             a_valid;
    logic             b_valid;
    logic             a_ready;
    logic             b_ready;
    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] a_y;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] b_y;
    logic             a_op;
    logic             b_op;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic             alu_op;
    logic             alu_issue;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             a_resp_valid;
    logic             b_resp_valid;
    logic [WIDTH-1:0] a_resp_result;
    logic [WIDTH-1:0] b_resp_result;
    logic             a_resp_overflow;
    logic             b_resp_overflow;
    logic [3:0]       inflight;

    modport slave (
        input  a_valid, b_valid, a_x, a_y, b_x, b_y, a_op, b_op,
        input  alu_result, alu_overflow,
        output a_ready, b_ready, alu_x, alu_y, alu_op, alu_issue,
        output a_resp_valid, b_resp_valid, a_resp_result, b_resp_result,
        output a_resp_overflow, b_resp_overflow, inflight
    );

    modport master (
        output a_valid, b_valid, a_x, a_y, b_x, b_y, a_op, b_op,
        output alu_result, alu_overflow,
        input  a_ready, b_ready, alu_x, alu_y, alu_op, alu_issue,
        input  a_resp_valid, b_resp_valid, a_resp_result, b_resp_result,
        input  a_resp_overflow, b_resp_overflow, inflight
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin arbiter feeding a shared fixed-latency ALU; a tag pipeline
// routes each ALU result back to the requester that issued it.
module alu_scheduler #(
    parameter int LATENCY = 3,
    parameter int WIDTH   = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_scheduler_if.slave bus
);
    localparam logic [3:0] INFLIGHT_MAX = 4'(LATENCY + 2);

    logic             grant_a;
    logic             grant_b;
    logic             accept;
    logic             last_grant_b;
    logic             issue_q;
    logic             issue_tag_q;
    logic             op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [LATENCY:1] pipe_v;
    logic [LATENCY:1] pipe_t;
    logic             ret_a;
    logic             ret_b;
    logic             a_rv_q;
    logic             b_rv_q;
    logic             a_ovf_q;
    logic             b_ovf_q;
    logic [WIDTH-1:0] a_res_q;
    logic [WIDTH-1:0] b_res_q;
    logic [3:0]       inflight_q;

    // Ready is a pure function of valid and last_grant, so it cannot loop back into valid.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = last_grant_b;
                grant_b = !last_grant_b;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    assign accept = grant_a | grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q      <= 1'b0;
            issue_tag_q  <= 1'b0;
            op_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            last_grant_b <= 1'b1;
        end else begin
            issue_q <= accept;
            if (accept) begin
                issue_tag_q  <= grant_b;
                op_q         <= grant_b ? bus.b_op : bus.a_op;
                x_q          <= grant_b ? bus.b_x  : bus.a_x;
                y_q          <= grant_b ? bus.b_y  : bus.a_y;
                last_grant_b <= grant_b;
            end
        end
    end

    // Stage k is valid LATENCY-k cycles before the ALU result for that issue appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            pipe_t <= '0;
        end else begin
            pipe_v[1] <= issue_q;
            pipe_t[1] <= issue_tag_q;
            for (int k = 2; k <= LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_t[k] <= pipe_t[k-1];
            end
        end
    end

    assign ret_a = pipe_v[LATENCY] & ~pipe_t[LATENCY];
    assign ret_b = pipe_v[LATENCY] &  pipe_t[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            a_res_q <= '0;
            b_res_q <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
        end else begin
            a_rv_q <= ret_a;
            b_rv_q <= ret_b;
            if (ret_a) begin
                a_res_q <= bus.alu_result;
                a_ovf_q <= bus.alu_overflow;
            end
            if (ret_b) begin
                b_res_q <= bus.alu_result;
                b_ovf_q <= bus.alu_overflow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else if (accept && !(a_rv_q || b_rv_q)) begin
            if (inflight_q != INFLIGHT_MAX) inflight_q <= inflight_q + 4'd1;
        end else if (!accept && (a_rv_q || b_rv_q)) begin
            if (inflight_q != 4'd0) inflight_q <= inflight_q - 4'd1;
        end
    end

    assign bus.a_ready         = grant_a;
    assign bus.b_ready         = grant_b;
    assign bus.alu_issue       = issue_q;
    assign bus.alu_op          = op_q;
    assign bus.alu_x           = x_q;
    assign bus.alu_y           = y_q;
    assign bus.a_resp_valid    = a_rv_q;
    assign bus.b_resp_valid    = b_rv_q;
    assign bus.a_resp_result   = a_res_q;
    assign bus.b_resp_result   = b_res_q;
    assign bus.a_resp_overflow = a_ovf_q;
    assign bus.b_resp_overflow = b_ovf_q;
    assign bus.inflight        = inflight_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: vector tables plus a scoreboard of expected issues,
// responses and in-flight counts, driven against a single-precision ALU model.
module tb_alu_scheduler;
    localparam int LATENCY = 3;
    localparam int WIDTH   = 32;

    localparam logic [31:0] F025 = 32'h3E80_0000;
    localparam logic [31:0] F05  = 32'h3F00_0000;
    localparam logic [31:0] F075 = 32'h3F40_0000;
    localparam logic [31:0] F1   = 32'h3F80_0000;
    localparam logic [31:0] F2   = 32'h4000_0000;
    localparam logic [31:0] F3   = 32'h4040_0000;
    localparam logic [31:0] F4   = 32'h4080_0000;
    localparam logic [31:0] F6   = 32'h40C0_0000;
    localparam logic [31:0] F16  = 32'h4180_0000;
    localparam logic [31:0] FBIG = 32'h7F00_0000;
    localparam logic [31:0] FINF = 32'h7F80_0000;

    typedef struct {
        logic        av, bv, aop, bop;
        logic [31:0] ax, ay, bx, by;
        logic        exp_a, exp_b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        int          acc;
        logic        tag, op, ovf;
        logic [31:0] x, y, res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] dut_peak = '0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_scheduler_if #(.WIDTH(WIDTH)) bus ();

    alu_scheduler #(.LATENCY(LATENCY), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // {overflow, result} of a single-precision add or multiply, truncating.
    function automatic logic [32:0] fp_model(input logic op, input logic [31:0] x, input logic [31:0] y);
        real         r;
        logic [63:0] d;
        int          e;
        r = op ? sp2real(x) * sp2real(y) : sp2real(x) + sp2real(y);
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {1'b0, d[63], 31'b0};
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'b0};
        if (e <= 0) return {1'b0, d[63], 31'b0};
        return {1'b0, d[63], e[7:0], d[51:29]};
    endfunction

    logic [LATENCY-1:0] mv = '0;
    logic [32:0]        md [LATENCY];

    always @(posedge clk) begin
        mv[0] <= bus.alu_issue;
        md[0] <= fp_model(bus.alu_op, bus.alu_x, bus.alu_y);
        for (int k = 1; k < LATENCY; k++) begin
            mv[k] <= mv[k-1];
            md[k] <= md[k-1];
        end
    end

    // Garbage outside the result cycle exposes any misaligned sampling.
    assign bus.alu_result   = mv[LATENCY-1] ? md[LATENCY-1][31:0] : 32'hDEAD_BEEF;
    assign bus.alu_overflow = mv[LATENCY-1] ? md[LATENCY-1][32]   : 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic vec_t mk(input logic av, input logic aop, input logic [31:0] ax, input logic [31:0] ay,
                                input logic bv, input logic bop, input logic [31:0] bx, input logic [31:0] by,
                                input logic ea, input logic eb, input logic [31:0] res, input logic ovf);
        vec_t v;
        v.av = av; v.aop = aop; v.ax = ax; v.ay = ay;
        v.bv = bv; v.bop = bop; v.bx = bx; v.by = by;
        v.exp_a = ea; v.exp_b = eb; v.res = res; v.ovf = ovf;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        bus.a_valid = v.av; bus.a_op = v.aop; bus.a_x = v.ax; bus.a_y = v.ay;
        bus.b_valid = v.bv; bus.b_op = v.bop; bus.b_x = v.bx; bus.b_y = v.by;
        #1;
        chk("a_ready", 32'(bus.a_ready), 32'(v.exp_a));
        chk("b_ready", 32'(bus.b_ready), 32'(v.exp_b));
        if (v.exp_a || v.exp_b) begin
            e.acc = cyc;
            e.tag = v.exp_b;
            e.op  = v.exp_b ? v.bop : v.aop;
            e.x   = v.exp_b ? v.bx  : v.ax;
            e.y   = v.exp_b ? v.by  : v.ay;
            e.res = v.res;
            e.ovf = v.ovf;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int   n_in;
        logic exp_iss;
        logic due;
        exp_t e;
        exp_t h;
        n_in    = 0;
        exp_iss = 1'b0;
        foreach (sbq[i]) begin
            if (sbq[i].acc < cyc) n_in++;
            if (sbq[i].acc == cyc - 1) begin
                exp_iss = 1'b1;
                e = sbq[i];
            end
        end
        chk("alu_issue", 32'(bus.alu_issue), 32'(exp_iss));
        if (exp_iss) begin
            chk("alu_x", bus.alu_x, e.x);
            chk("alu_y", bus.alu_y, e.y);
            chk("alu_op", 32'(bus.alu_op), 32'(e.op));
        end
        chk("inflight", 32'(bus.inflight), 32'(n_in));
        if (bus.inflight > dut_peak) dut_peak = bus.inflight;
        chk("ready_exclusive", 32'(bus.a_ready & bus.b_ready), 32'd0);
        due = (sbq.size() > 0) && (sbq[0].acc + 2 + LATENCY == cyc);
        if (due) begin
            h = sbq.pop_front();
            chk("a_resp_valid", 32'(bus.a_resp_valid), 32'(!h.tag));
            chk("b_resp_valid", 32'(bus.b_resp_valid), 32'(h.tag));
            chk("resp_result", h.tag ? bus.b_resp_result : bus.a_resp_result, h.res);
            chk("resp_overflow", 32'(h.tag ? bus.b_resp_overflow : bus.a_resp_overflow), 32'(h.ovf));
        end else begin
            chk("a_resp_idle", 32'(bus.a_resp_valid), 32'd0);
            chk("b_resp_idle", 32'(bus.b_resp_valid), 32'd0);
        end
    end

    initial begin
        vec_t cont[4];
        vec_t b2b[6];
        vec_t ovf[2];
        vec_t none;

        none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cont[0] = mk(1, 0, F1,  F2,   1, 1, F2, F3, 1, 0, F3,   0);
        cont[1] = mk(1, 0, F05, F025, 1, 1, F2, F3, 0, 1, F6,   0);
        cont[2] = mk(1, 0, F05, F025, 1, 1, F4, F4, 1, 0, F075, 0);
        cont[3] = mk(1, 0, F1,  F2,   1, 1, F4, F4, 0, 1, F16,  0);

        b2b[0] = mk(0, 0, 0, 0, 1, 0, F1,  F2,   0, 1, F3,   0);
        b2b[1] = mk(0, 0, 0, 0, 1, 1, F2,  F3,   0, 1, F6,   0);
        b2b[2] = mk(0, 0, 0, 0, 1, 0, F05, F025, 0, 1, F075, 0);
        b2b[3] = mk(0, 0, 0, 0, 1, 1, F4,  F4,   0, 1, F16,  0);
        b2b[4] = mk(0, 0, 0, 0, 1, 0, F2,  F2,   0, 1, F4,   0);
        b2b[5] = mk(0, 0, 0, 0, 1, 1, F1,  F05,  0, 1, F05,  0);

        ovf[0] = mk(0, 0, 0,    0,    1, 1, FBIG, F2, 0, 1, FINF, 1);
        ovf[1] = mk(1, 0, FBIG, FBIG, 0, 0, 0,    0,  1, 0, FINF, 1);

        // Valid held high during reset: ready must still stay low.
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.a_op = 1'b0; bus.b_op = 1'b1;
        bus.a_x = F1; bus.a_y = F2; bus.b_x = F2; bus.b_y = F3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
        chk("rst_alu_issue", 32'(bus.alu_issue), 32'd0);
        chk("rst_alu_x", bus.alu_x, 32'd0);
        chk("rst_alu_y", bus.alu_y, 32'd0);
        chk("rst_inflight", 32'(bus.inflight), 32'd0);
        chk("rst_b_resp_result", bus.b_resp_result, 32'd0);
        rst = 1'b0;

        // Contention straight out of reset: A, B, A, B.
        for (int i = 0; i < 4; i++) apply(cont[i]);
        idle(8);

        // Single add from A.
        apply(mk(1, 0, F1, F2, 0, 0, 0, 0, 1, 0, F3, 0));
        idle(8);

        // Six back-to-back operations from B.
        dut_peak = '0;
        for (int i = 0; i < 6; i++) apply(b2b[i]);
        idle(8);
        chk("inflight_peak", 32'(dut_peak), 32'(LATENCY + 2));

        // Overflow routed to the issuing requester.
        for (int i = 0; i < 2; i++) begin
            apply(ovf[i]);
            idle(7);
        end

        // Acceptance coinciding with a response leaves inflight unchanged.
        apply(mk(1, 0, F2, F2, 0, 0, 0, 0, 1, 0, F4, 0));
        idle(4);
        chk("simul_before", 32'(bus.inflight), 32'd1);
        apply(mk(1, 1, F4, F4, 0, 0, 0, 0, 1, 0, F16, 0));
        chk("simul_after", 32'(bus.inflight), 32'd1);
        idle(8);

        // Reset with three operations in flight; last grant before reset was A.
        apply(mk(1, 0, F1, F2, 0, 0, 0, 0, 1, 0, F3, 0));
        apply(mk(0, 0, 0, 0, 1, 1, F2, F3, 0, 1, F6, 0));
        apply(mk(1, 1, F4, F4, 0, 0, 0, 0, 1, 0, F16, 0));
        rst = 1'b1;
        sbq.delete();
        idle(1);
        rst = 1'b0;
        chk("post_rst_inflight", 32'(bus.inflight), 32'd0);
        apply(none);
        idle(8);
        apply(cont[0]);
        apply(cont[1]);
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
